// File: rtl/wb_spi_pkg.sv
// Shared register map, STATUS/CTRL bit positions and FIFO count field width
// for the Wishbone-to-SPI-slave bridge.
package wb_spi_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_CLEAR  = 2'd3
    } reg_sel_e;

    // Width of the rx_count / tx_count fields in STATUS
    localparam int CNT_W = 8;

    localparam int ST_RX_CNT = 0;
    localparam int ST_TX_CNT = 8;
    localparam int ST_FLAGS  = 16;  // rx_ovf, tx_udf, tx_ovf, frame_err at 16..19
    localparam int ST_SS     = 20;

    localparam int CTRL_CPOL    = 0;
    localparam int CTRL_CPHA    = 1;
    localparam int CTRL_LSB     = 2;
    localparam int CTRL_IRQ_RX  = 3;
    localparam int CTRL_IRQ_ERR = 4;
    localparam int CTRL_W       = 5;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO succeeds only when a pop
// happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_spi_fifo.sv
// Wishbone slave fronting an SPI slave with RX/TX FIFOs, sticky error flags
// and a level interrupt.
module wb_spi_fifo
    import wb_spi_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int SPI_WIDTH  = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] wbs_address,
    input  logic [DATA_WIDTH-1:0] wbs_writedata,
    output logic [DATA_WIDTH-1:0] wbs_readdata,
    input  logic                  wbs_strobe,
    input  logic                  wbs_cycle,
    input  logic                  wbs_write,
    output logic                  wbs_ack,
    input  logic                  mosi,
    input  logic                  ss,
    input  logic                  sclk,
    output logic                  miso,
    output logic                  spi_done,
    output logic                  irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(SPI_WIDTH + 1);

    logic [1:0]            sclk_sync, ss_sync, mosi_sync;
    logic                  sclk_q, ss_q;
    logic                  sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic                  lead, trail, sample_edge, shift_edge, last_bit;
    logic                  word_done, load, active;
    logic [2:0]            cfg;
    logic [BW-1:0]         bit_cnt;
    logic [SPI_WIDTH-1:0]  tx_sr, rx_sr, rx_word, load_word;
    logic [CTRL_W-1:0]     ctrl;
    logic [3:0]            flags, flag_set, flag_clr;
    logic                  req, wr, rd;
    reg_sel_e              sel;
    logic [DATA_WIDTH-1:0] rd_value;

    logic                  rx_push, rx_pop, rx_full, rx_empty;
    logic                  tx_push, tx_pop, tx_full, tx_empty;
    logic [SPI_WIDTH-1:0]  rx_dout, tx_dout;
    logic [CW-1:0]         rx_count, tx_count;
    logic                  unused_bits;

    assign unused_bits = ^{wbs_address[ADDR_WIDTH-1:2], wbs_writedata};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_q    <= 1'b0;
            ss_q      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            ss_sync   <= {ss_sync[0], ss};
            mosi_sync <= {mosi_sync[0], mosi};
            sclk_q    <= sclk_sync[1];
            ss_q      <= ss_sync[1];
        end
    end

    assign sclk_rise   = sclk_sync[1] & ~sclk_q;
    assign sclk_fall   = ~sclk_sync[1] & sclk_q;
    assign ss_fall     = ss_q & ~ss_sync[1];
    assign ss_rise     = ~ss_q & ss_sync[1];
    assign lead        = cfg[CTRL_CPOL] ? sclk_fall : sclk_rise;
    assign trail       = cfg[CTRL_CPOL] ? sclk_rise : sclk_fall;
    assign sample_edge = active & ~ss_fall & ~ss_rise & (cfg[CTRL_CPHA] ? trail : lead);
    assign shift_edge  = active & ~ss_fall & ~ss_rise & (cfg[CTRL_CPHA] ? lead : trail);
    assign last_bit    = (bit_cnt == BW'(SPI_WIDTH - 1));
    assign word_done   = sample_edge & last_bit;
    assign load        = ss_fall | word_done;
    assign load_word   = tx_empty ? '0 : tx_dout;
    assign rx_word     = cfg[CTRL_LSB] ? {mosi_sync[1], rx_sr[SPI_WIDTH-1:1]}
                                       : {rx_sr[SPI_WIDTH-2:0], mosi_sync[1]};

    // Shift edges before the first sample of a word are skipped so the MSB
    // loaded at ss fall / reload stays on miso for the master's first sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active  <= 1'b0;
            cfg     <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
        end else if (ss_fall) begin
            active  <= 1'b1;
            cfg     <= ctrl[2:0];
            bit_cnt <= '0;
            tx_sr   <= load_word;
            rx_sr   <= '0;
        end else if (ss_rise) begin
            active  <= 1'b0;
            bit_cnt <= '0;
        end else if (sample_edge) begin
            rx_sr <= rx_word;
            if (last_bit) begin
                bit_cnt <= '0;
                tx_sr   <= load_word;
            end else begin
                bit_cnt <= bit_cnt + BW'(1);
            end
        end else if (shift_edge && bit_cnt != '0) begin
            tx_sr <= cfg[CTRL_LSB] ? (tx_sr >> 1) : (tx_sr << 1);
        end
    end

    assign miso = active & (cfg[CTRL_LSB] ? tx_sr[0] : tx_sr[SPI_WIDTH-1]);

    assign req     = wbs_strobe & wbs_cycle & ~wbs_ack;
    assign sel     = reg_sel_e'(wbs_address[1:0]);
    assign wr      = req & wbs_write;
    assign rd      = req & ~wbs_write;
    assign rx_push = word_done;
    assign rx_pop  = rd & (sel == REG_DATA);
    assign tx_push = wr & (sel == REG_DATA);
    assign tx_pop  = load & ~tx_empty;

    assign flag_set[0] = word_done & rx_full & ~rx_pop;
    assign flag_set[1] = load & tx_empty;
    assign flag_set[2] = tx_push & tx_full & ~tx_pop;
    assign flag_set[3] = ss_rise & active & (bit_cnt != '0);
    assign flag_clr    = (wr && sel == REG_CLEAR) ? wbs_writedata[ST_FLAGS +: 4] : '0;

    always_comb begin
        rd_value = '0;
        case (sel)
            REG_DATA:   if (!rx_empty) rd_value[SPI_WIDTH-1:0] = rx_dout;
            REG_STATUS: begin
                rd_value[ST_RX_CNT +: CNT_W] = CNT_W'(rx_count);
                rd_value[ST_TX_CNT +: CNT_W] = CNT_W'(tx_count);
                rd_value[ST_FLAGS +: 4]      = flags;
                rd_value[ST_SS]              = ~ss_sync[1];
            end
            REG_CTRL:   rd_value[CTRL_W-1:0] = ctrl;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wbs_ack      <= 1'b0;
            wbs_readdata <= '0;
            ctrl         <= '0;
            flags        <= '0;
            spi_done     <= 1'b0;
        end else begin
            wbs_ack  <= req;
            spi_done <= word_done;
            flags    <= (flags & ~flag_clr) | flag_set;
            if (rd) wbs_readdata <= rd_value;
            if (wr && sel == REG_CTRL) ctrl <= wbs_writedata[CTRL_W-1:0];
        end
    end

    assign irq = (ctrl[CTRL_IRQ_RX] & ~rx_empty) | (ctrl[CTRL_IRQ_ERR] & (|flags));

    sync_fifo #(.WIDTH(SPI_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (rx_word),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    sync_fifo #(.WIDTH(SPI_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (wbs_writedata[SPI_WIDTH-1:0]),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

endmodule

// File: tb/tb_wb_spi_fifo.sv
// Directed-plus-random bench for wb_spi_fifo: an SPI master and Wishbone
// master drive the DUT, a queue-based model predicts every observed value.
`timescale 1ns/1ps
module tb_wb_spi_fifo;
    localparam int AW = 16, DW = 32, SW = 8, DEPTH = 8, H = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] wbs_address;
    logic [DW-1:0] wbs_writedata, wbs_readdata;
    logic          wbs_strobe, wbs_cycle, wbs_write, wbs_ack;
    logic          mosi, ss, sclk, miso, spi_done, irq;

    always #5 clk = ~clk;

    wb_spi_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SPI_WIDTH(SW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .wbs_address(wbs_address), .wbs_writedata(wbs_writedata), .wbs_readdata(wbs_readdata),
        .wbs_strobe(wbs_strobe), .wbs_cycle(wbs_cycle), .wbs_write(wbs_write), .wbs_ack(wbs_ack),
        .mosi(mosi), .ss(ss), .sclk(sclk), .miso(miso), .spi_done(spi_done), .irq(irq)
    );

    int tests = 0, fails = 0, done_cnt = 0, m_done = 0;
    logic [7:0] rx_q[$], tx_q[$];
    logic [3:0] m_flags = '0;
    logic [4:0] m_ctrl = '0;
    logic [2:0] m_cfg = '0;
    logic [7:0] m_shift = '0;

    always @(posedge clk) if (spi_done === 1'b1) done_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s = '0;
        s[7:0]   = 8'(rx_q.size());
        s[15:8]  = 8'(tx_q.size());
        s[19:16] = m_flags;
        s[20]    = ~ss;
        return s;
    endfunction

    function automatic logic m_irq();
        return (m_ctrl[3] && rx_q.size() > 0) || (m_ctrl[4] && |m_flags);
    endfunction

    task automatic model_load();
        if (tx_q.size() > 0) m_shift = tx_q.pop_front();
        else begin m_shift = '0; m_flags[1] = 1'b1; end
    endtask

    task automatic model_word(input logic [7:0] d);
        if (rx_q.size() < DEPTH) rx_q.push_back(d);
        else m_flags[0] = 1'b1;
        m_done++;
        model_load();
    endtask

    task automatic wb(input logic [1:0] a, input logic we, input logic [31:0] wd, output logic [31:0] rdat);
        int n = 0;
        @(negedge clk);
        wbs_address   = {14'($urandom), a};
        wbs_writedata = wd;
        wbs_write     = we;
        wbs_strobe    = 1'b1;
        wbs_cycle     = 1'b1;
        do begin @(negedge clk); n++; end while (wbs_ack !== 1'b1 && n < 8);
        chk("ack_latency", n, 1);
        rdat = wbs_readdata;
        wbs_strobe = 1'b0;
        wbs_cycle  = 1'b0;
        wbs_write  = 1'b0;
        @(negedge clk);
        chk("ack_one_clk", wbs_ack, 0);
    endtask

    task automatic data_write(input logic [31:0] d);
        logic [31:0] r;
        wb(2'd0, 1'b1, d, r);
        if (tx_q.size() < DEPTH) tx_q.push_back(d[7:0]);
        else m_flags[2] = 1'b1;
    endtask

    task automatic data_read(input string tag);
        logic [31:0] r, e;
        wb(2'd0, 1'b0, $urandom, r);
        e = (rx_q.size() > 0) ? {24'd0, rx_q.pop_front()} : 32'd0;
        chk(tag, r, e);
    endtask

    task automatic ctrl_write(input logic [4:0] v);
        logic [31:0] r;
        wb(2'd2, 1'b1, {27'($urandom), v}, r);
        m_ctrl = v;
        sclk = v[0];
        wait_clk(4);
        wb(2'd2, 1'b0, 32'd0, r);
        chk("ctrl_readback", r, {27'd0, v});
    endtask

    task automatic clear_write(input logic [31:0] v);
        logic [31:0] r;
        wb(2'd3, 1'b1, v, r);
        m_flags = m_flags & ~v[19:16];
    endtask

    task automatic check_status(input string tag);
        logic [31:0] r;
        wb(2'd1, 1'b0, 32'd0, r);
        chk(tag, r, m_status());
        chk({tag, "_irq"}, irq, m_irq());
    endtask

    task automatic ss_down();
        m_cfg = m_ctrl[2:0];
        ss = 1'b0;
        model_load();
        wait_clk(4);
    endtask

    task automatic ss_up(input logic partial);
        wait_clk(4);
        ss = 1'b1;
        if (partial) m_flags[3] = 1'b1;
        wait_clk(4);
    endtask

    // m_cfg: bit0 cpol, bit1 cpha, bit2 lsb_first
    task automatic spi_bits(input logic [7:0] d, input int n, output logic [7:0] mi);
        logic b, s;
        mi = '0;
        for (int i = 0; i < n; i++) begin
            b = m_cfg[2] ? d[i] : d[7-i];
            if (!m_cfg[1]) begin
                mosi = b;
                wait_clk(H);
                s = miso;
                sclk = ~m_cfg[0];
                wait_clk(H);
                sclk = m_cfg[0];
            end else begin
                sclk = ~m_cfg[0];
                mosi = b;
                wait_clk(H);
                s = miso;
                sclk = m_cfg[0];
                wait_clk(H);
            end
            if (m_cfg[2]) mi[i] = s; else mi[7-i] = s;
        end
    endtask

    task automatic spi_word(input logic [7:0] d, input string tag);
        logic [7:0] mi, e;
        e = m_shift;
        spi_bits(d, 8, mi);
        chk(tag, mi, e);
        model_word(d);
    endtask

    initial begin
        logic [4:0] cfgs [4];
        logic [7:0] w, junk;
        cfgs[0] = 5'b00010; cfgs[1] = 5'b00001; cfgs[2] = 5'b00011; cfgs[3] = 5'b00100;

        reset = 1'b0; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        wbs_address = '0; wbs_writedata = '0; wbs_strobe = 1'b0; wbs_cycle = 1'b0; wbs_write = 1'b0;
        wait_clk(3);
        chk("rst_ack", wbs_ack, 0);
        chk("rst_readdata", wbs_readdata, 0);
        chk("rst_miso", miso, 0);
        chk("rst_spi_done", spi_done, 0);
        chk("rst_irq", irq, 0);
        reset = 1'b1;
        wait_clk(2);
        check_status("status_reset");

        // Mode 0: send 0xA5 while TX holds 0x3C
        ctrl_write(5'b00000);
        data_write(32'h0000003C);
        ss_down();
        check_status("status_ss_low");
        spi_word(8'hA5, "miso_mode0");
        ss_up(1'b0);
        check_status("status_after_a5");
        chk("done_count_a5", done_cnt, m_done);
        data_read("read_a5");
        clear_write(32'h000F0000);

        // Modes 1..3 and lsb_first, two back-to-back words each
        for (int k = 0; k < 4; k++) begin
            data_write($urandom);
            data_write($urandom);
            ctrl_write(cfgs[k]);
            ss_down();
            spi_word((k % 2 == 0) ? 8'h81 : 8'h01, "miso_mode_first");
            spi_word(8'($urandom), "miso_mode_second");
            ss_up(1'b0);
            data_read("read_mode_first");
            data_read("read_mode_second");
        end
        check_status("status_modes");
        chk("done_count_modes", done_cnt, m_done);

        // RX overflow: nine words, no reads
        clear_write(32'h000F0000);
        ctrl_write(5'b00000);
        for (int k = 0; k < 9; k++) begin
            ss_down();
            spi_word(8'($urandom), "miso_empty_tx");
            ss_up(1'b0);
        end
        check_status("status_rx_overflow");
        clear_write(32'h00010000);
        check_status("status_rx_ovf_cleared");
        for (int k = 0; k < 8; k++) data_read("read_overflow_kept");
        data_read("read_empty_rx");

        // TX overflow, then eight back-to-back words draining TX through the pointer wrap
        clear_write(32'h000F0000);
        for (int k = 0; k < 9; k++) data_write($urandom);
        check_status("status_tx_overflow");
        ctrl_write(5'($urandom_range(0, 7)));
        ss_down();
        for (int k = 0; k < 8; k++) spi_word(8'($urandom), "miso_b2b");
        ss_up(1'b0);
        check_status("status_b2b");
        for (int k = 0; k < 8; k++) data_read("read_b2b");
        chk("done_count_b2b", done_cnt, m_done);

        // Frame error after 5 bits
        clear_write(32'h000F0000);
        ctrl_write(5'b10000);
        ss_down();
        spi_bits(8'($urandom), 5, junk);
        ss_up(1'b1);
        check_status("status_frame_error");
        ctrl_write(5'b01000);
        check_status("status_irq_err_disabled");

        // TX empty transfer, then irq on RX non-empty
        clear_write(32'h000F0000);
        ss_down();
        w = 8'($urandom);
        spi_word(w, "miso_underflow");
        ss_up(1'b0);
        check_status("status_underflow_irq_rx");
        data_read("read_underflow_word");
        check_status("status_irq_rx_drained");

        // Reset mid-word, then a clean 0x5A
        ctrl_write(5'b00000);
        data_write($urandom);
        ss_down();
        spi_bits(8'($urandom), 3, junk);
        reset = 1'b0;
        wait_clk(2);
        ss = 1'b1;
        sclk = 1'b0;
        wait_clk(2);
        chk("midrst_ack", wbs_ack, 0);
        chk("midrst_readdata", wbs_readdata, 0);
        chk("midrst_miso", miso, 0);
        chk("midrst_spi_done", spi_done, 0);
        chk("midrst_irq", irq, 0);
        reset = 1'b1;
        rx_q.delete(); tx_q.delete();
        m_flags = '0; m_ctrl = '0; m_shift = '0;
        wait_clk(3);
        data_write($urandom);
        data_write($urandom);
        ss_down();
        spi_word(8'h5A, "miso_after_reset");
        ss_up(1'b0);
        check_status("status_after_reset");
        data_read("read_5a");
        data_read("read_after_5a_empty");
        chk("done_count_final", done_cnt, m_done);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
